mem_resp_stage: RTL
===================

MEM_RESP_STAGE -- requirements
Module: mem_resp_stage

Interface
REQ-001 SHALL have parameter CNT_W, default 2: width of the discard counter for cancelled data responses.
REQ-002 SHALL have port clk  input  1: single clock; all state is updated on its rising edge.
REQ-003 SHALL have port resetn  input  1: reset, asynchronous and active-low.
REQ-004 SHALL have port es_to_ms_valid  input  1: the execute stage holds a valid instruction.
REQ-005 SHALL have port es_to_ms_bus  input  165: [164] mem_req (a data request was accepted by the SRAM), [163:161] ld_type, [160:0] base fields.
REQ-006 SHALL use this base field layout in es_to_ms_bus[160:0]: the write-back bus layout below, with bits [63:32] carrying alu_result in place of final_result.
REQ-007 SHALL have port ms_allowin  output  1: this stage can accept an instruction this cycle.
REQ-008 SHALL have port ms_to_ws_valid  output  1: the write-back stage may capture ms_to_ws_bus.
REQ-009 SHALL have port ms_to_ws_bus  output  161: {refill, nextpc[32], tlbp, tlb_found, tlb_index[4], tlbr, tlbwi, BadVAddr[32], bd, eret_flush, cp0_addr[8], dst_is_cp0, src_is_cp0, except, exccode[5], gr_we, dest[5], final_result[32], pc[32]}, MSB first.
REQ-010 SHALL have port ws_allowin  input  1: the write-back stage accepts an instruction.
REQ-011 SHALL have port ws_to_ms_exbus  input  1: clear_all (pipeline flush).
REQ-012 SHALL have port data_sram_data_ok  input  1: a data response is present this cycle.
REQ-013 SHALL have port data_sram_rdata  input  32: the response data.
REQ-014 SHALL have port ms_to_ds_bus  output  40: {ms_valid, fwd_we, dest[5], fwd_data[32], fwd_pending}, for forwarding and interlock.

Function
REQ-015 SHALL encode ld_type as follows: 000 = non-load, 001 = lb, 010 = lbu, 011 = lh, 100 = lhu, 101 = lw; codes 110 and 111 SHALL behave as lw.
REQ-016 SHALL capture es_to_ms_bus into the stage register and set ms_valid when es_to_ms_valid && ms_allowin.
- The bus register SHALL be left unchanged otherwise.
REQ-017 SHALL define ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
REQ-018 SHALL define ms_to_ws_valid = ms_valid && ms_ready_go && !clear_all.
REQ-019 SHALL define ms_ready_go = !mem_req || except || data_ok_eff || buf_valid.
- data_ok_eff = data_sram_data_ok && discard_cnt==0.
REQ-020 SHALL, when data_ok_eff && ms_valid && mem_req && !buf_valid && !ws_allowin, latch data_sram_rdata into a 32-bit buffer and set buf_valid.
REQ-021 SHALL clear buf_valid when the instruction leaves the stage or clear_all is asserted.
REQ-022 SHALL select load data as buf_valid ? buffer : data_sram_rdata.
- Byte/halfword lanes SHALL be selected by alu_result[1:0] (halfword lane by bit 1).
- lb/lh SHALL be sign-extended; lbu/lhu SHALL be zero-extended.
REQ-023 SHALL set final_result to the extended load data for loads, and to alu_result otherwise.
- All other output fields SHALL pass through unchanged.
REQ-024 SHALL, on clear_all, clear ms_valid and buf_valid in the next cycle.
- If ms_valid && mem_req && !except && !ready_go, discard_cnt SHALL increment in the same cycle.
REQ-025 SHALL decrement discard_cnt on each data_sram_data_ok while discard_cnt != 0, and SHALL not use that response.
- Simultaneous increment and decrement SHALL leave the count unchanged.
- The count SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-026 SHALL drive ms_to_ds_bus as follows:
- fwd_we = ms_valid && gr_we && !except.
- fwd_pending = ms_valid && ld_type!=0 && !ms_ready_go.
- fwd_data = final_result.
REQ-027 SHALL accept a new instruction in the same cycle the current one leaves (back-to-back, no bubble).

Reset
REQ-028 SHALL, while resetn is low, force ms_valid=0, buf_valid=0, discard_cnt=0, and hence ms_to_ws_valid=0 and ms_allowin=1.
- The bus register and data buffer SHALL be don't-care during reset.
REQ-029 SHALL, when reset is asserted mid-load, drop the pending instruction, with no later output caused by it.

Verification
REQ-030 SHALL cover a lw to address 0x...4 with mem_req=1 and data_ok two cycles later carrying rdata 0x8899AABB -> final_result=0x8899AABB, and ms_to_ws_valid held low until the data_ok cycle.
REQ-031 SHALL cover lb at alu_result[1:0]=3 with rdata 0x80112233 -> 0xFFFFFF80, and lhu at offset 2 with the same rdata -> 0x00008011.
REQ-032 SHALL cover data_ok arriving while ws_allowin=0 -> rdata is buffered, and the correct value is delivered when ws_allowin=1 with the bus lines changed.
REQ-033 SHALL cover clear_all while a lw is waiting -> discard_cnt=1, the next data_ok is ignored, and the following load receives its own data.
REQ-034 SHALL cover a load with except=1 and mem_req=0 -> passes in 1 cycle, fwd_we=0, fwd_pending=0.
REQ-035 SHALL cover resetn pulsed low mid-wait -> ms_valid=0 immediately (asynchronously), and ms_allowin=1.

Source files
------------

// File: rtl/mem_resp_stage.sv
// mem_resp_stage: memory-response pipeline stage; waits for load data, buffers it under
// write-back backpressure, extends sub-word loads and discards responses orphaned by a flush.
module mem_resp_stage #(
  parameter int CNT_W = 2
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         es_to_ms_valid,
  input  logic [164:0] es_to_ms_bus,
  output logic         ms_allowin,
  output logic         ms_to_ws_valid,
  output logic [160:0] ms_to_ws_bus,
  input  logic         ws_allowin,
  input  logic         ws_to_ms_exbus,
  input  logic         data_sram_data_ok,
  input  logic [31:0]  data_sram_rdata,
  output logic [39:0]  ms_to_ds_bus
);
  logic             ms_valid_q, ms_valid_d;
  logic             buf_valid_q, buf_valid_d;
  logic [CNT_W-1:0] discard_cnt_q, discard_cnt_d;
  logic [164:0]     bus_q, bus_d;
  logic [31:0]      buf_q, buf_d;
  logic             clear_all, mem_req, except, gr_we, data_ok_eff, ms_ready_go;
  logic             leave, buf_set, inc, dec;
  logic [2:0]       ld_type;
  logic [31:0]      alu_result, ld_data, final_result;
  logic [7:0]       lane_b;
  logic [15:0]      lane_h;

  assign clear_all   = ws_to_ms_exbus;
  assign mem_req     = bus_q[164];
  assign ld_type     = bus_q[163:161];
  assign except      = bus_q[75];
  assign gr_we       = bus_q[69];
  assign alu_result  = bus_q[63:32];
  assign data_ok_eff = data_sram_data_ok && (discard_cnt_q == '0);
  assign ms_ready_go = !mem_req || except || data_ok_eff || buf_valid_q;
  assign ms_allowin  = !ms_valid_q || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid_q && ms_ready_go && !clear_all;
  assign leave       = ms_valid_q && ms_ready_go && ws_allowin;
  assign buf_set     = data_ok_eff && ms_valid_q && mem_req && !buf_valid_q && !ws_allowin;
  // A flushed load still owes the SRAM one response; count it so it can be dropped later.
  assign inc         = clear_all && ms_valid_q && mem_req && !except && !ms_ready_go;
  assign dec         = data_sram_data_ok && (discard_cnt_q != '0);

  always_comb begin
    ld_data      = buf_valid_q ? buf_q : data_sram_rdata;
    lane_b       = ld_data[{alu_result[1:0], 3'b000} +: 8];
    lane_h       = alu_result[1] ? ld_data[31:16] : ld_data[15:0];
    final_result = (ld_type == 3'd0) ? alu_result :
                   (ld_type == 3'd1) ? {{24{lane_b[7]}}, lane_b} :
                   (ld_type == 3'd2) ? {24'd0, lane_b} :
                   (ld_type == 3'd3) ? {{16{lane_h[15]}}, lane_h} :
                   (ld_type == 3'd4) ? {16'd0, lane_h} : ld_data;
  end

  always_comb begin
    ms_valid_d    = clear_all ? 1'b0 : ms_allowin ? es_to_ms_valid : ms_valid_q;
    bus_d         = (es_to_ms_valid && ms_allowin) ? es_to_ms_bus : bus_q;
    buf_valid_d   = (clear_all || leave) ? 1'b0 : buf_set ? 1'b1 : buf_valid_q;
    buf_d         = buf_set ? data_sram_rdata : buf_q;
    discard_cnt_d = (inc && !dec && discard_cnt_q != '1) ? discard_cnt_q + CNT_W'(1) :
                    (dec && !inc) ? discard_cnt_q - CNT_W'(1) : discard_cnt_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid_q    <= 1'b0;
      buf_valid_q   <= 1'b0;
      discard_cnt_q <= '0;
    end else begin
      ms_valid_q    <= ms_valid_d;
      buf_valid_q   <= buf_valid_d;
      discard_cnt_q <= discard_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    bus_q <= bus_d;
    buf_q <= buf_d;
  end

  assign ms_to_ws_bus = {bus_q[160:64], final_result, bus_q[31:0]};
  assign ms_to_ds_bus = {ms_valid_q, ms_valid_q && gr_we && !except, bus_q[68:64], final_result,
                         ms_valid_q && (ld_type != 3'd0) && !ms_ready_go};
endmodule
